// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate pipeline.
// Holds the vector-tracking FSM state type and the default parameter values
// used by mac_pipe, mac_sat_add and mac_pipe_if.
package mac_pkg;

    localparam int unsigned MAC_DATA_W   = 8;
    localparam int unsigned MAC_ACC_W    = 20;
    localparam int unsigned MAC_CNT_W    = 8;
    localparam int unsigned MAC_SIGNED   = 0;
    localparam int unsigned MAC_SATURATE = 1;

    // IDLE: no vector open; ACCUM: at least one non-last element accepted
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } mac_state_e;

endpackage

// File: rtl/mac_pipe_if.sv
// Operand/result handshake bundle for mac_pipe.
// master: drives operands (in_valid, in_last, a, b) and out_ready,
//         observes in_ready and the result (out_valid, mac_out, elem_cnt, overflow).
// slave : the mac_pipe side, directions reversed.
interface mac_pipe_if
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W,
    parameter int unsigned ACC_W  = MAC_ACC_W,
    parameter int unsigned CNT_W  = MAC_CNT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  mac_out;
    logic [CNT_W-1:0]  elem_cnt;
    logic              overflow;

    modport master (
        output in_valid, in_last, a, b, out_ready,
        input  in_ready, out_valid, mac_out, elem_cnt, overflow
    );

    modport slave (
        input  in_valid, in_last, a, b, out_ready,
        output in_ready, out_valid, mac_out, elem_cnt, overflow
    );

endinterface

// File: rtl/mac_sat_add.sv
// Combinational accumulator adder with overflow detect.
// Ports: acc, addend (ACC_W, same signedness) -> sum_c (clamped or wrapped
// per SATURATE), ovf_c (the true sum does not fit in ACC_W).
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W    = MAC_ACC_W,
    parameter int unsigned SIGNED   = MAC_SIGNED,
    parameter int unsigned SATURATE = MAC_SATURATE
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum_c,
    output logic             ovf_c
);

    localparam bit SAT_EN = (SATURATE != 0);

    logic [ACC_W-1:0] raw_c;
    logic [ACC_W-1:0] clamp_c;

    generate
        if (SIGNED != 0) begin : g_signed
            // Two's-complement overflow: like-signed inputs, differently-signed result
            assign raw_c   = acc + addend;
            assign ovf_c   = (acc[ACC_W-1] == addend[ACC_W-1]) &&
                             (raw_c[ACC_W-1] != acc[ACC_W-1]);
            // Overflow direction follows the operand sign: negative -> min, positive -> max
            assign clamp_c = {acc[ACC_W-1], {(ACC_W-1){~acc[ACC_W-1]}}};
        end else begin : g_unsigned
            logic [ACC_W:0] wide_c;
            assign wide_c  = {1'b0, acc} + {1'b0, addend};
            assign raw_c   = wide_c[ACC_W-1:0];
            assign ovf_c   = wide_c[ACC_W];
            assign clamp_c = '1;
        end
    endgenerate

    assign sum_c = (ovf_c && SAT_EN) ? clamp_c : raw_c;

endmodule

// File: rtl/mac_pipe.sv
// Two-stage pipelined dot-product (multiply-accumulate) engine.
// Ports: sys_clock, sys_rst_n (async active-low), sclr (sync clear),
//        bus (mac_pipe_if.slave): operand pairs in with in_valid/in_ready/in_last,
//        results out with out_valid/out_ready plus mac_out, elem_cnt, overflow.
// Stage 1 registers the extended product; the next advancing edge folds it into
// the accumulator and, on the last element, publishes the result and restarts.
// ACC_W must be at least 2*DATA_W.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W   = MAC_DATA_W,
    parameter int unsigned ACC_W    = MAC_ACC_W,
    parameter int unsigned CNT_W    = MAC_CNT_W,
    parameter int unsigned SIGNED   = MAC_SIGNED,
    parameter int unsigned SATURATE = MAC_SATURATE
) (
    input  logic        sys_clock,
    input  logic        sys_rst_n,
    input  logic        sclr,
    mac_pipe_if.slave   bus
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    mac_state_e        state_q, state_d;

    logic              adv_c;
    logic              accept_c;
    logic              load_c;

    logic [PROD_W-1:0] a_ext_c, b_ext_c, prod_c;
    logic [ACC_W-1:0]  prod_ext_c;

    logic              s1_valid_q;
    logic              s1_last_q;
    logic [ACC_W-1:0]  s1_prod_q;

    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_acc_q;

    logic [ACC_W-1:0]  sum_c;
    logic              add_ovf_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              ovf_next_c;

    logic              out_valid_q;
    logic [ACC_W-1:0]  mac_out_q;
    logic [CNT_W-1:0]  elem_cnt_q;
    logic              overflow_q;

    // Whole pipeline moves unless a held result is not being taken
    assign adv_c    = !(out_valid_q && !bus.out_ready);
    assign accept_c = bus.in_valid && adv_c;
    assign load_c   = s1_valid_q && s1_last_q;

    // Full-width product; operands pre-extended so the low PROD_W bits are exact
    generate
        if (SIGNED != 0) begin : g_sext
            assign a_ext_c = {{DATA_W{bus.a[DATA_W-1]}}, bus.a};
            assign b_ext_c = {{DATA_W{bus.b[DATA_W-1]}}, bus.b};
        end else begin : g_zext
            assign a_ext_c = {{DATA_W{1'b0}}, bus.a};
            assign b_ext_c = {{DATA_W{1'b0}}, bus.b};
        end
    endgenerate

    assign prod_c = a_ext_c * b_ext_c;

    // Widen the product to the accumulator width
    generate
        if (ACC_W > PROD_W) begin : g_widen
            logic ext_bit_c;
            assign ext_bit_c  = (SIGNED != 0) ? prod_c[PROD_W-1] : 1'b0;
            assign prod_ext_c = {{(ACC_W-PROD_W){ext_bit_c}}, prod_c};
        end else begin : g_same
            assign prod_ext_c = prod_c[ACC_W-1:0];
        end
    endgenerate

    mac_sat_add #(
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_add (
        .acc    (acc_q),
        .addend (s1_prod_q),
        .sum_c  (sum_c),
        .ovf_c  (add_ovf_c)
    );

    // Element count sticks at its maximum instead of wrapping
    assign cnt_inc_c  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_next_c = ovf_acc_q | add_ovf_c;

    // FSM state register
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else if (sclr) begin
            state_q <= ST_IDLE;
        end else if (adv_c) begin
            state_q <= state_d;
        end
    end

    // FSM next state: tracks whether a vector is open
    always_comb begin
        state_d = state_q;
        if (accept_c) begin
            state_d = bus.in_last ? ST_IDLE : ST_ACCUM;
        end
    end

    // Stage 1: product and last flag of the accepted pair
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
        end else if (sclr) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
        end else if (adv_c) begin
            s1_valid_q <= accept_c;
            if (accept_c) begin
                s1_last_q <= bus.in_last;
                s1_prod_q <= prod_ext_c;
            end
        end
    end

    // Running sum, count and sticky overflow; restart after the last element
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else if (sclr) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else if (adv_c && s1_valid_q) begin
            if (s1_last_q) begin
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_acc_q <= 1'b0;
            end else begin
                acc_q     <= sum_c;
                cnt_q     <= cnt_inc_c;
                ovf_acc_q <= ovf_next_c;
            end
        end
    end

    // Result register: a new load keeps out_valid high even as the old one drains
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid_q <= 1'b0;
            mac_out_q   <= '0;
            elem_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else if (sclr) begin
            out_valid_q <= 1'b0;
            mac_out_q   <= '0;
            elem_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else if (adv_c) begin
            out_valid_q <= load_c;
            if (load_c) begin
                mac_out_q  <= sum_c;
                elem_cnt_q <= cnt_inc_c;
                overflow_q <= ovf_next_c;
            end
        end
    end

    assign bus.in_ready  = adv_c;
    assign bus.out_valid = out_valid_q;
    assign bus.mac_out   = mac_out_q;
    assign bus.elem_cnt  = elem_cnt_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: four instances with different widths/modes share one
// stimulus stream; an arithmetic dot-product model predicts every result.
// Instances: 0 = 4b/10b unsigned saturate, 1 = 4b/8b unsigned saturate,
//            2 = 4b/8b unsigned wrap,     3 = 4b/8b signed saturate.
module tb_mac_pipe;

    localparam int NI = 4;
    localparam int ACCW [NI] = '{10, 8, 8, 8};
    localparam int SGN  [NI] = '{0, 0, 0, 1};
    localparam int SAT  [NI] = '{1, 1, 0, 1};

    typedef struct packed {
        logic [NI-1:0][9:0] mac;
        logic [7:0]         cnt;
        logic [NI-1:0]      ovf;
    } exp_t;

    logic       sys_clock = 1'b0;
    logic       sys_rst_n;
    logic       sclr;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [3:0] a, b;

    always #5 sys_clock = ~sys_clock;

    mac_pipe_if #(.DATA_W(4), .ACC_W(10), .CNT_W(8)) if0 ();
    mac_pipe_if #(.DATA_W(4), .ACC_W(8),  .CNT_W(8)) if1 ();
    mac_pipe_if #(.DATA_W(4), .ACC_W(8),  .CNT_W(8)) if2 ();
    mac_pipe_if #(.DATA_W(4), .ACC_W(8),  .CNT_W(8)) if3 ();

    assign if0.in_valid = in_valid;  assign if0.in_last = in_last;
    assign if0.a = a;  assign if0.b = b;  assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_last = in_last;
    assign if1.a = a;  assign if1.b = b;  assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_last = in_last;
    assign if2.a = a;  assign if2.b = b;  assign if2.out_ready = out_ready;
    assign if3.in_valid = in_valid;  assign if3.in_last = in_last;
    assign if3.a = a;  assign if3.b = b;  assign if3.out_ready = out_ready;

    mac_pipe #(.DATA_W(4), .ACC_W(10), .CNT_W(8), .SIGNED(0), .SATURATE(1)) u0 (
        .sys_clock(sys_clock), .sys_rst_n(sys_rst_n), .sclr(sclr), .bus(if0));
    mac_pipe #(.DATA_W(4), .ACC_W(8), .CNT_W(8), .SIGNED(0), .SATURATE(1)) u1 (
        .sys_clock(sys_clock), .sys_rst_n(sys_rst_n), .sclr(sclr), .bus(if1));
    mac_pipe #(.DATA_W(4), .ACC_W(8), .CNT_W(8), .SIGNED(0), .SATURATE(0)) u2 (
        .sys_clock(sys_clock), .sys_rst_n(sys_rst_n), .sclr(sclr), .bus(if2));
    mac_pipe #(.DATA_W(4), .ACC_W(8), .CNT_W(8), .SIGNED(1), .SATURATE(1)) u3 (
        .sys_clock(sys_clock), .sys_rst_n(sys_rst_n), .sclr(sclr), .bus(if3));

    logic [NI-1:0]       ir, vo, ov;
    logic [NI-1:0][9:0]  mo;
    logic [NI-1:0][7:0]  ec;

    assign ir = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};
    assign vo = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
    assign ov = {if3.overflow, if2.overflow, if1.overflow, if0.overflow};
    assign mo = {10'(if3.mac_out), 10'(if2.mac_out), 10'(if1.mac_out), if0.mac_out};
    assign ec = {if3.elem_cnt, if2.elem_cnt, if1.elem_cnt, if0.elem_cnt};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: exact running sums and the queue of results owed
    longint        m_acc [NI];
    int            m_cnt;
    logic [NI-1:0] m_ovf;
    exp_t          expq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NI; i++) m_acc[i] = 0;
        m_cnt = 0;
        m_ovf = '0;
    endtask

    // Add one product to every configuration's running sum
    task automatic model_feed(input logic [3:0] aa, input logic [3:0] bb, input bit last);
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            longint p, s, mx, mn, span;
            span = longint'(1) << ACCW[i];
            if (SGN[i] != 0) begin
                p  = longint'($signed(aa)) * longint'($signed(bb));
                mx = span / 2 - 1;
                mn = -(span / 2);
            end else begin
                p  = longint'(aa) * longint'(bb);
                mx = span - 1;
                mn = 0;
            end
            s = m_acc[i] + p;
            if (s > mx || s < mn) begin
                m_ovf[i] = 1'b1;
                if (SAT[i] != 0) begin
                    s = (s > mx) ? mx : mn;
                end else begin
                    s = (s - mn) % span;
                    if (s < 0) s += span;
                    s += mn;
                end
            end
            m_acc[i] = s;
            e.mac[i] = 10'(s & (span - 1));
        end
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (last) begin
            e.cnt = 8'(m_cnt);
            e.ovf = m_ovf;
            expq.push_back(e);
            model_clear();
        end
    endtask

    // One clock: check held result and ready, then advance the model at the edge
    task automatic tick(output bit accepted);
        bit cons;
        exp_t e;
        #2;
        accepted = in_valid && ir[0];
        cons     = vo[0] && out_ready;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("in_ready%0d", i), ir[i], !(vo[i] && !out_ready));
            if (vo[i]) begin
                if (expq.size() == 0) begin
                    check($sformatf("unexpected_valid%0d", i), vo[i], 1'b0);
                end else begin
                    e = expq[0];
                    check($sformatf("mac_out%0d", i), mo[i], e.mac[i]);
                    check($sformatf("elem_cnt%0d", i), ec[i], e.cnt);
                    check($sformatf("overflow%0d", i), ov[i], e.ovf[i]);
                end
            end
        end
        @(posedge sys_clock);
        if (!sys_rst_n) begin
            model_clear();
            expq.delete();
        end else if (sclr) begin
            model_clear();
            expq.delete();
        end else begin
            if (cons && expq.size() > 0) void'(expq.pop_front());
            if (accepted) model_feed(a, b, in_last);
        end
        @(negedge sys_clock);
    endtask

    task automatic drive(input logic [3:0] aa, input logic [3:0] bb, input bit last);
        bit acc;
        in_valid = 1'b1; a = aa; b = bb; in_last = last;
        tick(acc);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0; in_last = 1'b0;
        repeat (n) tick(acc);
    endtask

    initial begin
        bit acc;
        int rem;
        int nvec;

        sys_rst_n = 1'b0; sclr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        model_clear();
        repeat (2) @(negedge sys_clock);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_out_valid%0d", i), vo[i], 1'b0);
            check($sformatf("rst_mac_out%0d", i), mo[i], 10'd0);
            check($sformatf("rst_elem_cnt%0d", i), ec[i], 8'd0);
            check($sformatf("rst_overflow%0d", i), ov[i], 1'b0);
            check($sformatf("rst_in_ready%0d", i), ir[i], 1'b1);
        end
        sys_rst_n = 1'b1;

        // Basic dot product and its latency
        drive(4'd3, 4'd4, 1'b0);
        drive(4'd5, 4'd6, 1'b1);
        check("lat_after_accept", vo[0], 1'b0);
        idle(1);
        check("lat_second_edge", vo[0], 1'b1);
        check("dot_42", mo[0], 10'd42);
        check("dot_cnt2", ec[0], 8'd2);
        check("dot_noovf", ov[0], 1'b0);

        // Overflow: saturate vs wrap
        drive(4'd15, 4'd15, 1'b0);
        drive(4'd15, 4'd15, 1'b1);
        idle(1);
        check("sat_255", mo[1], 10'd255);
        check("sat_ovf", ov[1], 1'b1);
        check("wrap_194", mo[2], 10'd194);
        check("wrap_ovf", ov[2], 1'b1);
        check("wide_450", mo[0], 10'd450);
        check("wide_noovf", ov[0], 1'b0);

        // Signed operands
        drive(4'h8, 4'd7, 1'b0);
        drive(4'h8, 4'h8, 1'b1);
        idle(1);
        check("signed_8", mo[3], 10'd8);
        check("signed_cnt2", ec[3], 8'd2);
        idle(1);

        // Back-to-back single-element vectors against a stalled consumer
        out_ready = 1'b0;
        drive(4'd2, 4'd2, 1'b1);
        drive(4'd1, 4'd7, 1'b1);
        check("stall_in_ready", ir[0], 1'b0);
        check("stall_first_4", mo[0], 10'd4);
        in_valid = 1'b1; a = 4'd9; b = 4'd9; in_last = 1'b1;
        tick(acc);
        tick(acc);
        check("stall_not_taken", 32'(acc), 32'd0);
        check("stall_hold_4", mo[0], 10'd4);
        out_ready = 1'b1;
        tick(acc);
        in_valid = 1'b0; in_last = 1'b0;
        check("release_valid", vo[0], 1'b1);
        check("release_second_7", mo[0], 10'd7);
        idle(1);
        check("release_third_81", mo[0], 10'd81);
        idle(1);

        // Synchronous clear mid-vector, with a concurrent offer that must be dropped
        drive(4'd3, 4'd3, 1'b0);
        idle(1);
        sclr = 1'b1;
        drive(4'd5, 4'd5, 1'b0);
        sclr = 1'b0;
        check("sclr_valid", vo[0], 1'b0);
        check("sclr_mac", mo[0], 10'd0);
        drive(4'd2, 4'd2, 1'b1);
        idle(1);
        check("post_sclr_4", mo[0], 10'd4);
        check("post_sclr_cnt1", ec[0], 8'd1);
        idle(1);

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        drive(4'd3, 4'd4, 1'b1);
        idle(1);
        check("pre_rst_valid", vo[0], 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_rst_valid%0d", i), vo[i], 1'b0);
            check($sformatf("async_rst_mac%0d", i), mo[i], 10'd0);
            check($sformatf("async_rst_ready%0d", i), ir[i], 1'b1);
        end
        model_clear();
        expq.delete();
        @(negedge sys_clock);
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        drive(4'd1, 4'd1, 1'b0);
        drive(4'd2, 4'd3, 1'b1);
        idle(1);
        check("post_rst_7", mo[0], 10'd7);
        check("post_rst_cnt2", ec[0], 8'd2);
        idle(1);

        // Element counter saturation on a long vector
        for (int k = 0; k < 260; k++) drive(4'($urandom), 4'($urandom), k == 259);
        for (int k = 0; k < 5 && !vo[0]; k++) idle(1);
        check("cnt_sat_valid", vo[0], 1'b1);
        check("cnt_sat_255", ec[0], 8'd255);
        idle(1);

        // Random vectors with random gaps and back-pressure
        nvec = 0;
        rem  = $urandom_range(1, 6);
        for (int k = 0; k < 2000 && nvec < 40; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 4'($urandom);
            b         = 4'($urandom);
            in_last   = (rem == 1);
            tick(acc);
            if (acc) begin
                rem--;
                if (rem == 0) begin
                    nvec++;
                    rem = $urandom_range(1, 6);
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 40 && expq.size() > 0; k++) idle(1);
        check("random_vectors", 32'(nvec), 32'd40);
        check("drain_empty", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_pipe.md
MAC_PIPE -- requirements
Module: mac_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the width of operands a and b.
REQ-002 SHALL have parameter ACC_W, default 20, the accumulator and result width; legal only when ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter CNT_W, default 8, the element-counter width.
REQ-004 SHALL have parameter SIGNED, default 0: 0 means unsigned operands, 1 means two's-complement operands.
REQ-005 SHALL have parameter SATURATE, default 1: 1 clamps the accumulator on overflow, 0 wraps modulo 2^ACC_W.
REQ-006 SHALL have port sys_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-008 SHALL have port sclr, input, 1 bit: synchronous clear.
REQ-009 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-010 SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-011 SHALL have port in_last, input, 1 bit: the offered pair ends the current vector.
REQ-012 SHALL have ports a and b, input, DATA_W bits each: the operands.
REQ-013 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-015 SHALL have port mac_out, output, ACC_W bits: the dot-product result.
REQ-016 SHALL have port elem_cnt, output, CNT_W bits: the number of elements in the reported vector.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, set if any accumulation in the reported vector overflowed.

Function
REQ-018 SHALL accept an operand pair on a rising edge where in_valid && in_ready.
REQ-019 SHALL compute a*b at the full 2*DATA_W width, signed or unsigned per SIGNED, and sign- or zero-extend it to ACC_W.
REQ-020 SHALL define the advance enable adv = !(out_valid && !out_ready); SHALL drive in_ready = adv combinationally.
REQ-021 SHALL, when adv is low, hold every pipeline register, the accumulator, the counter and the FSM.
REQ-022 SHALL, at the acceptance edge, register the product, the last flag and a valid bit into stage 1.
REQ-023 SHALL, at the next advancing edge, add the stage-1 product into the accumulator and increment the element counter.
REQ-024 SHALL, when that stage-1 entry has last=1, load mac_out, elem_cnt and overflow from the post-add values, set out_valid, and clear the accumulator, counter and sticky overflow in the same edge.
REQ-025 SHALL give a latency of exactly 2 rising edges from the acceptance of the last pair to out_valid=1, with no stall.
REQ-026 SHALL clear out_valid on an edge with out_valid && out_ready, unless a new result loads on that same edge, in which case out_valid stays 1.
REQ-027 SHALL sustain full throughput: one pair per cycle and back-to-back vectors with no bubble when out_ready=1.
REQ-028 SHALL, when SATURATE=1, clamp the accumulator to the ACC_W max or min (signed or unsigned per SIGNED) and set overflow; when SATURATE=0, wrap and still set overflow.
REQ-029 SHALL saturate elem_cnt at 2^CNT_W-1 with no wrap.
REQ-030 SHALL run an FSM with states IDLE (no vector open) and ACCUM (vector open):
- IDLE -> ACCUM on acceptance with in_last=0.
- ACCUM -> IDLE on acceptance with in_last=1.
- IDLE with an accepted in_last=1 (single-element vector) stays in IDLE.
REQ-031 SHALL give sclr priority over all function: clear stage 1, accumulator, counter, out_valid, mac_out, elem_cnt and overflow; FSM to IDLE; discard any concurrent acceptance.
REQ-032 SHALL hold mac_out, elem_cnt and overflow stable while out_valid=1 and out_ready=0.

Reset
REQ-033 SHALL, on sys_rst_n low, asynchronously set all registers to the sclr values of REQ-031 (every output 0, FSM IDLE), so in_ready=1.
REQ-034 SHALL, on reset mid-vector or mid-hold, drop the partial sum and the pending result; SHALL then accept a fresh vector on the first edge after release.

Structure
REQ-035 SHALL place the FSM state enum and default parameter constants in shared package mac_pkg.
REQ-036 SHALL implement the saturating/wrapping adder with overflow detect as combinational sub-module mac_sat_add.

Verification
REQ-037 SHALL cover, with DATA_W=4, ACC_W=10, unsigned: pairs (3,4) then (5,6,last), out_ready=1 -> mac_out=42, elem_cnt=2, overflow=0, out_valid 2 edges after the last acceptance.
REQ-038 SHALL cover back-to-back vectors (2,2,last), (1,7,last) with out_ready=0 -> in_ready=0 after the first result; on out_ready=1, results 4 then 7 in order with no data loss.
REQ-039 SHALL cover DATA_W=4, ACC_W=8, unsigned, SATURATE=1: (15,15), (15,15,last) -> mac_out=255, overflow=1; SATURATE=0 -> mac_out=194, overflow=1.
REQ-040 SHALL cover SIGNED=1, DATA_W=4, ACC_W=8: (-8,7), (-8,-8,last) -> mac_out=8, elem_cnt=2.
REQ-041 SHALL cover sclr asserted mid-vector after (3,3), then (2,2,last) -> mac_out=4, elem_cnt=1.
REQ-042 SHALL cover sys_rst_n low while out_valid=1 -> out_valid=0, mac_out=0, in_ready=1 immediately, with no clock edge required.
